// File: rtl/ipif_pkg.sv
// ipif_pkg: shared register-mode enum, mode field width and CE helper for IPIF blocks
package ipif_pkg;

    typedef enum logic [1:0] {
        RW    = 2'd0,
        RO    = 2'd1,
        W1C   = 2'd2,
        PULSE = 2'd3
    } reg_mode_e;

    localparam int IPIF_MODE_W = 2;

    function automatic logic is_onehot(input logic [63:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/ipif_reg_slot.sv
// ipif_reg_slot: one register slot whose access mode is fixed by parameter
module ipif_reg_slot
    import ipif_pkg::*;
#(
    parameter int        DW        = 32,
    parameter reg_mode_e MODE      = RW,
    parameter int        PULSE_LEN = 1,
    parameter logic [DW-1:0] DEFAULT = '0
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_data,
    input  logic [DW/8-1:0] i_be,
    input  logic [DW-1:0] i_set,
    output logic [DW-1:0] o_q
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [DW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_clr;

    // expand byte enables into a bit mask
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < DW/8; k++) w_mask[8*k +: 8] = {8{i_be[k]}};
    end

    assign w_clr = i_wr ? (i_data & w_mask) : '0;
    assign o_q   = r_q;

    // mode-specific update; set beats clear for W1C, counter times PULSE data
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= (MODE == RW) ? DEFAULT : '0;
            r_cnt <= '0;
        end else if (MODE == W1C) begin
            r_q <= (r_q & ~w_clr) | i_set;
        end else if (MODE == RW && i_wr) begin
            r_q <= (r_q & ~w_mask) | (i_data & w_mask);
        end else if (MODE == PULSE && i_wr) begin
            r_q   <= i_data & w_mask;
            r_cnt <= CW'(PULSE_LEN);
        end else if (MODE == PULSE && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_q <= '0;
        end
    end

endmodule

// File: rtl/ipif_register_bank.sv
// ipif_register_bank: IPIF slave register bank with per-register access modes
module ipif_register_bank
    import ipif_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_REG = 4,
    parameter logic [2*N_REG-1:0] REG_MODE = '0,
    parameter int PULSE_LEN = 1,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] DEFAULTS = '0
) (
    input  logic                                 clk,
    input  logic                                 IPIF_bus2ip_resetn,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        IPIF_bus2ip_data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      IPIF_bus2ip_be,
    input  logic [N_REG-1:0]                     IPIF_bus2ip_wrce,
    input  logic [N_REG-1:0]                     IPIF_bus2ip_rdce,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        IPIF_ip2bus_data,
    output logic                                 IPIF_ip2bus_wrack,
    output logic                                 IPIF_ip2bus_rdack,
    output logic                                 IPIF_ip2bus_error,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  parameters_out,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  parameters_in,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]  status_set,
    output logic [N_REG-1:0]                     reg_wr_stb,
    output logic [N_REG-1:0]                     reg_rd_stb,
    output logic                                 irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [N_REG-1:0] w_wr;
    logic          w_ro_wr;
    logic          w_w1c_any;
    logic          w_err;
    logic [DW-1:0] w_rd_data;

    logic          r_wrack;
    logic          r_rdack;
    logic          r_err;
    logic [DW-1:0] r_data;
    logic [N_REG-1:0] r_wr_stb;
    logic [N_REG-1:0] r_rd_stb;
    logic          r_irq;

    assign w_wr_ok = is_onehot(64'(IPIF_bus2ip_wrce));
    assign w_rd_ok = is_onehot(64'(IPIF_bus2ip_rdce));

    for (genvar g = 0; g < N_REG; g++) begin : g_slot
        ipif_reg_slot #(
            .DW        (DW),
            .MODE      (reg_mode_e'(REG_MODE[IPIF_MODE_W*g +: IPIF_MODE_W])),
            .PULSE_LEN (PULSE_LEN),
            .DEFAULT   (DEFAULTS[g*DW +: DW])
        ) u_slot (
            .clk     (clk),
            .i_rst_n (IPIF_bus2ip_resetn),
            .i_wr    (w_wr[g]),
            .i_data  (IPIF_bus2ip_data),
            .i_be    (IPIF_bus2ip_be),
            .i_set   (status_set[g*DW +: DW]),
            .o_q     (parameters_out[g*DW +: DW])
        );
    end

    // CE decode, read mux and W1C summary; multi-hot CEs select nothing
    always_comb begin
        w_wr      = '0;
        w_ro_wr   = 1'b0;
        w_w1c_any = 1'b0;
        w_rd_data = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_wr[i]    = w_wr_ok && IPIF_bus2ip_wrce[i] &&
                         (reg_mode_e'(REG_MODE[IPIF_MODE_W*i +: IPIF_MODE_W]) != RO);
            w_ro_wr    = w_ro_wr | (w_wr_ok && IPIF_bus2ip_wrce[i] &&
                         (reg_mode_e'(REG_MODE[IPIF_MODE_W*i +: IPIF_MODE_W]) == RO));
            w_w1c_any  = w_w1c_any | ((reg_mode_e'(REG_MODE[IPIF_MODE_W*i +: IPIF_MODE_W]) == W1C) &&
                         (|parameters_out[i*DW +: DW]));
            w_rd_data  = w_rd_data | ((w_rd_ok && IPIF_bus2ip_rdce[i]) ?
                         ((reg_mode_e'(REG_MODE[IPIF_MODE_W*i +: IPIF_MODE_W]) == RO) ?
                          parameters_in[i*DW +: DW] : parameters_out[i*DW +: DW]) : '0);
        end
    end

    assign w_err = ((|IPIF_bus2ip_wrce) && (!w_wr_ok || w_ro_wr)) ||
                   ((|IPIF_bus2ip_rdce) && !w_rd_ok);

    // bus response, strobes and irq all land one cycle after the CE cycle
    always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
        if (!IPIF_bus2ip_resetn) begin
            r_wrack  <= 1'b0;
            r_rdack  <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_wr_stb <= '0;
            r_rd_stb <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_wrack  <= |IPIF_bus2ip_wrce;
            r_rdack  <= |IPIF_bus2ip_rdce;
            r_err    <= w_err;
            r_data   <= w_rd_data;
            r_wr_stb <= w_wr;
            r_rd_stb <= w_rd_ok ? IPIF_bus2ip_rdce : '0;
            r_irq    <= w_w1c_any;
        end
    end

    assign IPIF_ip2bus_wrack = r_wrack;
    assign IPIF_ip2bus_rdack = r_rdack;
    assign IPIF_ip2bus_error = r_err;
    assign IPIF_ip2bus_data  = r_data;
    assign reg_wr_stb        = r_wr_stb;
    assign reg_rd_stb        = r_rd_stb;
    assign irq               = r_irq;

endmodule

// File: tb/tb_ipif_register_bank.sv
// tb_ipif_register_bank: directed tests of the IPIF register bank
module tb_ipif_register_bank;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  data;
    logic [3:0]   be;
    logic [3:0]   wrce;
    logic [3:0]   rdce;
    logic [31:0]  rdata;
    logic         wrack;
    logic         rdack;
    logic         err;
    logic [127:0] pout;
    logic [127:0] pin;
    logic [127:0] sset;
    logic [3:0]   wr_stb;
    logic [3:0]   rd_stb;
    logic         irq;

    int n_checks = 0;
    int n_pass   = 0;

    ipif_register_bank #(
        .C_S_AXI_DATA_WIDTH (32),
        .N_REG              (4),
        .REG_MODE           (8'hE4),
        .PULSE_LEN          (3),
        .DEFAULTS           (128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF)
    ) dut (
        .clk                (clk),
        .IPIF_bus2ip_resetn (resetn),
        .IPIF_bus2ip_data   (data),
        .IPIF_bus2ip_be     (be),
        .IPIF_bus2ip_wrce   (wrce),
        .IPIF_bus2ip_rdce   (rdce),
        .IPIF_ip2bus_data   (rdata),
        .IPIF_ip2bus_wrack  (wrack),
        .IPIF_ip2bus_rdack  (rdack),
        .IPIF_ip2bus_error  (err),
        .parameters_out     (pout),
        .parameters_in      (pin),
        .status_set         (sset),
        .reg_wr_stb         (wr_stb),
        .reg_rd_stb         (rd_stb),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return pout[i*32 +: 32];
    endfunction

    task automatic test_reset();
        resetn = 1'b0; data = '0; be = '0; wrce = '0; rdce = '0; pin = '0; sset = '0;
        cyc(); cyc();
        resetn = 1'b1;
        cyc();
        n_checks++; if (slot(0) !== 32'hDEADBEEF) $display("FAIL reset_slot0 got %h exp %h", slot(0), 32'hDEADBEEF); else n_pass++;
        n_checks++; if (pout[127:32] !== 96'h0) $display("FAIL reset_slots123 got %h exp 0", pout[127:32]); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
        n_checks++; if ({wrack, rdack, err} !== 3'b000) $display("FAIL reset_acks got %b exp 000", {wrack, rdack, err}); else n_pass++;
    endtask

    task automatic test_rw();
        wrce = 4'b0001; data = 32'h12345678; be = 4'b0101;
        cyc();
        wrce = '0;
        n_checks++; if (slot(0) !== 32'hDE34BE78) $display("FAIL rw_value got %h exp %h", slot(0), 32'hDE34BE78); else n_pass++;
        n_checks++; if ({wrack, err, wr_stb} !== 6'b10_0001) $display("FAIL rw_wrack got %b exp 100001", {wrack, err, wr_stb}); else n_pass++;
        cyc();
        n_checks++; if ({wrack, wr_stb} !== 5'b0_0000) $display("FAIL rw_ack_drop got %b exp 00000", {wrack, wr_stb}); else n_pass++;
        rdce = 4'b0001;
        cyc();
        rdce = '0;
        n_checks++; if (rdata !== 32'hDE34BE78) $display("FAIL rw_read got %h exp %h", rdata, 32'hDE34BE78); else n_pass++;
        n_checks++; if ({rdack, err, rd_stb} !== 6'b10_0001) $display("FAIL rw_rdack got %b exp 100001", {rdack, err, rd_stb}); else n_pass++;
    endtask

    task automatic test_ro();
        wrce = 4'b0010; data = 32'h55555555; be = 4'hF;
        cyc();
        wrce = '0;
        n_checks++; if ({wrack, err, wr_stb} !== 6'b11_0000) $display("FAIL ro_write got %b exp 110000", {wrack, err, wr_stb}); else n_pass++;
        n_checks++; if (slot(1) !== 32'h0) $display("FAIL ro_no_update got %h exp 0", slot(1)); else n_pass++;
        pin[63:32] = 32'hA5A5A5A5;
        rdce = 4'b0010;
        cyc();
        rdce = '0;
        n_checks++; if (rdata !== 32'hA5A5A5A5) $display("FAIL ro_read got %h exp %h", rdata, 32'hA5A5A5A5); else n_pass++;
        n_checks++; if ({rdack, err, rd_stb} !== 6'b10_0010) $display("FAIL ro_rdack got %b exp 100010", {rdack, err, rd_stb}); else n_pass++;
    endtask

    task automatic test_w1c();
        sset[67] = 1'b1;
        cyc();
        sset[67] = 1'b0;
        n_checks++; if (slot(2) !== 32'h8) $display("FAIL w1c_set got %h exp 8", slot(2)); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL w1c_irq_lag got %b exp 0", irq); else n_pass++;
        cyc();
        n_checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_rise got %b exp 1", irq); else n_pass++;
        sset[67] = 1'b1; wrce = 4'b0100; data = 32'h8; be = 4'hF;
        cyc();
        sset[67] = 1'b0; wrce = '0;
        n_checks++; if (slot(2) !== 32'h8) $display("FAIL w1c_set_wins got %h exp 8", slot(2)); else n_pass++;
        cyc();
        wrce = 4'b0100; data = 32'h8; be = 4'hF;
        cyc();
        wrce = '0;
        n_checks++; if (slot(2) !== 32'h0) $display("FAIL w1c_clear got %h exp 0", slot(2)); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_hold got %b exp 1", irq); else n_pass++;
        cyc();
        n_checks++; if (irq !== 1'b0) $display("FAIL w1c_irq_drop got %b exp 0", irq); else n_pass++;
    endtask

    task automatic test_pulse();
        wrce = 4'b1000; data = 32'hFF; be = 4'hF;
        cyc();
        wrce = '0;
        n_checks++; if (slot(3) !== 32'hFF) $display("FAIL pulse_c1 got %h exp ff", slot(3)); else n_pass++;
        n_checks++; if (wr_stb !== 4'b1000) $display("FAIL pulse_stb got %b exp 1000", wr_stb); else n_pass++;
        cyc();
        n_checks++; if (slot(3) !== 32'hFF) $display("FAIL pulse_c2 got %h exp ff", slot(3)); else n_pass++;
        cyc();
        n_checks++; if (slot(3) !== 32'hFF) $display("FAIL pulse_c3 got %h exp ff", slot(3)); else n_pass++;
        cyc();
        n_checks++; if (slot(3) !== 32'h0) $display("FAIL pulse_end got %h exp 0", slot(3)); else n_pass++;
        wrce = 4'b1000; data = 32'hFF;
        cyc();
        wrce = '0;
        cyc();
        wrce = 4'b1000; data = 32'h0F;
        cyc();
        wrce = '0;
        n_checks++; if (slot(3) !== 32'h0F) $display("FAIL pulse_reload got %h exp 0f", slot(3)); else n_pass++;
        cyc(); cyc();
        n_checks++; if (slot(3) !== 32'h0F) $display("FAIL pulse_reload_c3 got %h exp 0f", slot(3)); else n_pass++;
        cyc();
        n_checks++; if (slot(3) !== 32'h0) $display("FAIL pulse_reload_end got %h exp 0", slot(3)); else n_pass++;
        rdce = 4'b1000;
        cyc();
        rdce = '0;
        n_checks++; if ({rdack, rdata} !== {1'b1, 32'h0}) $display("FAIL pulse_read got %b/%h exp 1/0", rdack, rdata); else n_pass++;
    endtask

    task automatic test_multihot();
        wrce = 4'b0011; data = 32'hFFFFFFFF; be = 4'hF;
        cyc();
        wrce = '0;
        n_checks++; if ({wrack, err, wr_stb} !== 6'b11_0000) $display("FAIL mh_write got %b exp 110000", {wrack, err, wr_stb}); else n_pass++;
        n_checks++; if (slot(0) !== 32'hDE34BE78) $display("FAIL mh_no_update got %h exp %h", slot(0), 32'hDE34BE78); else n_pass++;
        rdce = 4'b1100;
        cyc();
        rdce = '0;
        n_checks++; if ({rdack, err, rd_stb} !== 6'b11_0000) $display("FAIL mh_read got %b exp 110000", {rdack, err, rd_stb}); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL mh_rdata got %h exp 0", rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        wrce = 4'b0001; rdce = 4'b0001; data = 32'h11111111; be = 4'hF;
        cyc();
        n_checks++; if ({wrack, rdack, err} !== 3'b110) $display("FAIL b2b_ack1 got %b exp 110", {wrack, rdack, err}); else n_pass++;
        n_checks++; if (rdata !== 32'hDE34BE78) $display("FAIL b2b_old_read got %h exp %h", rdata, 32'hDE34BE78); else n_pass++;
        data = 32'h22222222;
        cyc();
        wrce = '0; rdce = '0;
        n_checks++; if ({wrack, rdack} !== 2'b11) $display("FAIL b2b_ack2 got %b exp 11", {wrack, rdack}); else n_pass++;
        n_checks++; if (rdata !== 32'h11111111) $display("FAIL b2b_read2 got %h exp 11111111", rdata); else n_pass++;
        n_checks++; if (slot(0) !== 32'h22222222) $display("FAIL b2b_value got %h exp 22222222", slot(0)); else n_pass++;
        cyc();
        n_checks++; if ({wrack, rdack} !== 2'b00) $display("FAIL b2b_idle got %b exp 00", {wrack, rdack}); else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        wrce = 4'b1000; data = 32'hFF; be = 4'hF;
        cyc();
        wrce = '0;
        n_checks++; if (slot(3) !== 32'hFF) $display("FAIL rmp_start got %h exp ff", slot(3)); else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (slot(3) !== 32'h0) $display("FAIL rmp_drop got %h exp 0", slot(3)); else n_pass++;
        n_checks++; if (slot(0) !== 32'hDEADBEEF) $display("FAIL rmp_default got %h exp %h", slot(0), 32'hDEADBEEF); else n_pass++;
        cyc();
        resetn = 1'b1;
        cyc();
        n_checks++; if (slot(3) !== 32'h0) $display("FAIL rmp_after got %h exp 0", slot(3)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rw();
        test_ro();
        test_w1c();
        test_pulse();
        test_multihot();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
